spmv_row_reducer: RTL and testbench

- Consumer stage directly downstream of the adder-stage output queue (`sfifo`) in the SpMV merge pipeline.
- Pops `{last, row, val}` entries in first-word-fall-through style: data is valid whenever `q_empty`=0, and `q_rd_en` pops it.
- Sums runs of consecutive entries with the same row index into one result.
- Emits one `(row, sum)` per run on a valid/ready output toward the y-vector writeback.

---
 rtl/spmv_pkg.sv | 24 ++
 rtl/spmv_row_reducer_if.sv | 40 ++++
 rtl/spmv_out_reg.sv | 57 +++++
 rtl/spmv_row_reducer.sv | 167 ++++++++++++++++
 tb/tb_spmv_row_reducer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spmv_pkg.sv
// Shared types and width constants for the SpMV merge pipeline row reducer.
package spmv_pkg;

  // Default widths; these match the existing pipeline definitions header.
  localparam int SPMV_ROW_WIDTH = 32;
  localparam int SPMV_VAL_WIDTH = 32;
  localparam int SPMV_DSIZE     = 1 + SPMV_ROW_WIDTH + SPMV_VAL_WIDTH;
  localparam int SPMV_CNT_WIDTH = 32;

  // One adder-stage queue entry, packed exactly as the sfifo stores it.
  typedef struct packed {
    logic                      last;
    logic [SPMV_ROW_WIDTH-1:0] row;
    logic [SPMV_VAL_WIDTH-1:0] val;
  } q_entry_t;

  // Reducer control states.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ACC   = 2'd1,
    S_HOLD  = 2'd2
  } red_state_e;

endpackage

// File: rtl/spmv_row_reducer_if.sv
// Bus bundle for the row reducer: FWFT queue head on the input side and the
// valid/ready result stream toward y-vector writeback on the output side.
// master = the reducer's view, slave = the surrounding pipeline's view.
interface spmv_row_reducer_if
  import spmv_pkg::*;
#(
  parameter int ROW_WIDTH = SPMV_ROW_WIDTH,
  parameter int VAL_WIDTH = SPMV_VAL_WIDTH,
  parameter int DSIZE     = SPMV_DSIZE
);

  logic [DSIZE-1:0]     q_data;
  logic                 q_empty;
  logic                 q_rd_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [ROW_WIDTH-1:0] out_row;
  logic [VAL_WIDTH-1:0] out_val;

  modport master (
    input  q_data,
    input  q_empty,
    input  out_ready,
    output q_rd_en,
    output out_valid,
    output out_row,
    output out_val
  );

  modport slave (
    output q_data,
    output q_empty,
    output out_ready,
    input  q_rd_en,
    input  out_valid,
    input  out_row,
    input  out_val
  );

endinterface

// File: rtl/spmv_out_reg.sv
// Single-entry valid/ready holding register for finished row sums, plus the
// count of results accepted downstream. A load and an accept may coincide,
// so the register sustains one result per cycle.
module spmv_out_reg #(
  parameter int ROW_WIDTH = 32,
  parameter int VAL_WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 load,
  input  logic [ROW_WIDTH-1:0] load_row,
  input  logic [VAL_WIDTH-1:0] load_val,
  input  logic                 out_ready,
  output logic                 slot,
  output logic                 out_valid,
  output logic [ROW_WIDTH-1:0] out_row,
  output logic [VAL_WIDTH-1:0] out_val,
  output logic [CNT_WIDTH-1:0] out_cnt
);

  logic                 valid_reg;
  logic [ROW_WIDTH-1:0] row_reg;
  logic [VAL_WIDTH-1:0] val_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic                 xfer;

  assign xfer      = valid_reg && out_ready;
  // Register can take a new result when empty or being drained this cycle.
  assign slot      = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_row   = row_reg;
  assign out_val   = val_reg;
  assign out_cnt   = cnt_reg;

  // Hold data stable until accepted; a load takes priority over the drain.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      valid_reg <= 1'b0;
      row_reg   <= '0;
      val_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      if (load) begin
        valid_reg <= 1'b1;
        row_reg   <= load_row;
        val_reg   <= load_val;
      end else if (xfer) begin
        valid_reg <= 1'b0;
      end
      if (xfer) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spmv_row_reducer.sv
// Row reducer: pops {last,row,val} entries from the FWFT adder-stage queue,
// sums consecutive entries sharing a row index, and emits one (row,sum) per
// run. A run closes on a row change or on an entry flagged last; runs are
// never merged across a last boundary.
module spmv_row_reducer
  import spmv_pkg::*;
#(
  parameter int ROW_WIDTH = SPMV_ROW_WIDTH,
  parameter int VAL_WIDTH = SPMV_VAL_WIDTH,
  parameter int DSIZE     = 1 + ROW_WIDTH + VAL_WIDTH,
  parameter int CNT_WIDTH = SPMV_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_b,
  spmv_row_reducer_if.master    q,
  output logic [CNT_WIDTH-1:0]  out_cnt,
  output logic                  busy
);

  // Queue head fields.
  logic                 h_present;
  logic                 h_last;
  logic [ROW_WIDTH-1:0] h_row;
  logic [VAL_WIDTH-1:0] h_val;

  assign h_present = !q.q_empty;
  assign h_last    = q.q_data[DSIZE-1];
  assign h_row     = q.q_data[VAL_WIDTH +: ROW_WIDTH];
  assign h_val     = q.q_data[VAL_WIDTH-1:0];

  red_state_e           state_reg, state_next;
  logic [ROW_WIDTH-1:0] acc_row_reg, acc_row_next;
  logic [VAL_WIDTH-1:0] acc_val_reg, acc_val_next;
  logic                 acc_last_reg, acc_last_next;

  logic                 pop;
  logic                 load;
  logic                 slot;
  logic                 match;
  logic                 out_valid_w;
  logic [ROW_WIDTH-1:0] out_row_w;
  logic [VAL_WIDTH-1:0] out_val_w;

  assign match = (h_row == acc_row_reg);

  // Result register and accepted-result counter.
  spmv_out_reg #(
    .ROW_WIDTH (ROW_WIDTH),
    .VAL_WIDTH (VAL_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst_b     (rst_b),
    .load      (load),
    .load_row  (acc_row_reg),
    .load_val  (acc_val_reg),
    .out_ready (q.out_ready),
    .slot      (slot),
    .out_valid (out_valid_w),
    .out_row   (out_row_w),
    .out_val   (out_val_w),
    .out_cnt   (out_cnt)
  );

  assign q.out_valid = out_valid_w;
  assign q.out_row   = out_row_w;
  assign q.out_val   = out_val_w;

  // Pops never escape while reset is held, and never on an empty queue.
  assign q.q_rd_en = pop && rst_b && h_present;

  assign busy = (state_reg != S_EMPTY) || out_valid_w;

  // State and accumulator registers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_reg    <= S_EMPTY;
      acc_row_reg  <= '0;
      acc_val_reg  <= '0;
      acc_last_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_row_reg  <= acc_row_next;
      acc_val_reg  <= acc_val_next;
      acc_last_reg <= acc_last_next;
    end
  end

  // Next-state, pop and result-load decisions.
  always_comb begin
    state_next    = state_reg;
    acc_row_next  = acc_row_reg;
    acc_val_next  = acc_val_reg;
    acc_last_next = acc_last_reg;
    pop           = 1'b0;
    load          = 1'b0;

    case (state_reg)
      S_EMPTY: begin
        if (h_present) begin
          pop           = 1'b1;
          acc_row_next  = h_row;
          acc_val_next  = h_val;
          acc_last_next = h_last;
          state_next    = S_ACC;
        end
      end

      S_ACC: begin
        if (!acc_last_reg) begin
          // Open run: extend it, or close it on a row change.
          if (h_present) begin
            if (match) begin
              pop           = 1'b1;
              acc_val_next  = acc_val_reg + h_val;
              acc_last_next = h_last;
            end else if (slot) begin
              load          = 1'b1;
              pop           = 1'b1;
              acc_row_next  = h_row;
              acc_val_next  = h_val;
              acc_last_next = h_last;
            end else begin
              state_next = S_HOLD;
            end
          end
        end else begin
          // Closed run: ship it as soon as the result register frees up.
          if (slot) begin
            load = 1'b1;
            if (h_present) begin
              pop           = 1'b1;
              acc_row_next  = h_row;
              acc_val_next  = h_val;
              acc_last_next = h_last;
            end else begin
              state_next = S_EMPTY;
            end
          end else begin
            state_next = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // Finished run waiting for the result register; then refill at once.
        if (slot) begin
          load = 1'b1;
          if (h_present) begin
            pop           = 1'b1;
            acc_row_next  = h_row;
            acc_val_next  = h_val;
            acc_last_next = h_last;
            state_next    = S_ACC;
          end else begin
            state_next = S_EMPTY;
          end
        end
      end

      default: begin
        state_next = S_EMPTY;
      end
    endcase
  end

endmodule

// File: tb/tb_spmv_row_reducer.sv
// Self-checking bench for spmv_row_reducer: an FWFT queue model feeds the
// reducer, results are collected and compared against a run-grouping model.
module tb_spmv_row_reducer;
  import spmv_pkg::*;

  typedef struct packed {
    logic [31:0] row;
    logic [31:0] val;
  } res_t;

  logic        clk;
  logic        rst_b;
  logic [31:0] out_cnt;
  logic        busy;

  spmv_row_reducer_if #(.ROW_WIDTH(32), .VAL_WIDTH(32), .DSIZE(65)) intf ();

  spmv_row_reducer #(
    .ROW_WIDTH (32),
    .VAL_WIDTH (32),
    .DSIZE     (65),
    .CNT_WIDTH (32)
  ) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .q       (intf),
    .out_cnt (out_cnt),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  q_entry_t    fifo[$];
  res_t        obs[$];
  int          pop_cycles[$];
  int          xfer_cycles[$];
  int          cycle;
  int          viol;
  int          checks;
  int          errors;
  logic [31:0] cnt_exp;

  function automatic q_entry_t mk(input int unsigned row, input int unsigned val, input bit last);
    q_entry_t e;
    e.last = last;
    e.row  = row;
    e.val  = val;
    return e;
  endfunction

  // Reference: group consecutive same-row entries; a last flag closes a run.
  function automatic void model(input q_entry_t ents[$], output res_t exp[$]);
    bit   have;
    bit   closed;
    res_t cur;
    have   = 1'b0;
    closed = 1'b0;
    cur    = '0;
    exp    = {};
    foreach (ents[i]) begin
      if (have && !closed && ents[i].row == cur.row) begin
        cur.val = cur.val + ents[i].val;
      end else begin
        if (have) exp.push_back(cur);
        cur.row = ents[i].row;
        cur.val = ents[i].val;
        have    = 1'b1;
      end
      closed = ents[i].last;
    end
    if (have && closed) exp.push_back(cur);
  endfunction

  // One clock: drive queue head and ready, observe pop and transfer.
  task automatic step(input bit rdy);
    logic [64:0] junk;
    bit          pop;
    intf.out_ready = rdy;
    if (fifo.size() > 0) begin
      intf.q_empty = 1'b0;
      intf.q_data  = fifo[0];
    end else begin
      junk         = {$urandom(), $urandom(), 1'b0};
      intf.q_empty = 1'b1;
      intf.q_data  = junk;
    end
    @(negedge clk);
    pop = intf.q_rd_en;
    if (pop && intf.q_empty) viol++;
    if (intf.out_valid && intf.out_ready) begin
      obs.push_back('{row: intf.out_row, val: intf.out_val});
      xfer_cycles.push_back(cycle);
      $display("xfer cycle=%0d row=%0d val=0x%08h", cycle, intf.out_row, intf.out_val);
    end
    if (pop && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pop_cycles.push_back(cycle);
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic load_fifo(input q_entry_t ents[$]);
    obs.delete();
    pop_cycles.delete();
    xfer_cycles.delete();
    foreach (ents[i]) fifo.push_back(ents[i]);
  endtask

  task automatic run(input int n_exp, input bit rand_rdy, output bit ok);
    int budget;
    budget = 4000;
    while ((obs.size() < n_exp || fifo.size() > 0) && budget > 0) begin
      step(rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1);
      budget--;
    end
    ok = (budget > 0);
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    fifo.push_back(mk(1, 1, 1));
    step(1'b1);
    step(1'b1);
    checks++; if (intf.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", intf.out_valid); end
    checks++; if (out_cnt !== 32'd0) begin errors++; $display("FAIL reset_out_cnt got=%0d want=0", out_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (intf.q_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b want=0", intf.q_rd_en); end
    checks++; if (fifo.size() !== 1) begin errors++; $display("FAIL reset_queue_untouched got=%0d want=1", fifo.size()); end
    fifo.delete();
    rst_b   = 1'b1;
    cnt_exp = 0;
    step(1'b1);
  endtask

  task automatic test_single_run();
    q_entry_t ents[$];
    res_t     exp[$];
    bit       ok;
    ents.push_back(mk(3, 5, 0));
    ents.push_back(mk(3, 7, 0));
    ents.push_back(mk(3, 1, 1));
    model(ents, exp);
    load_fifo(ents);
    run(exp.size(), 1'b0, ok);
    cnt_exp += exp.size();
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=%0d outputs want=%0d", obs.size(), exp.size()); end
    checks++; if (obs.size() !== 1 || obs[0] !== {32'd3, 32'd13}) begin errors++; $display("FAIL single_result got=%0d,(%0d,%0d) want=1,(3,13)", obs.size(), obs[0].row, obs[0].val); end
    checks++; if (out_cnt !== cnt_exp) begin errors++; $display("FAIL single_cnt got=%0d want=%0d", out_cnt, cnt_exp); end
    checks++; if (pop_cycles.size() !== 3 || pop_cycles[2] - pop_cycles[0] !== 2) begin errors++; $display("FAIL single_pops_consecutive got=%0d pops span=%0d want=3 span=2", pop_cycles.size(), pop_cycles[2] - pop_cycles[0]); end
    checks++; if (xfer_cycles.size() !== 1 || xfer_cycles[0] - pop_cycles[2] !== 2) begin errors++; $display("FAIL single_latency got=%0d want=2", xfer_cycles[0] - pop_cycles[2]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_row_change();
    q_entry_t ents[$];
    res_t     exp[$];
    bit       ok;
    ents.push_back(mk(1, 2, 0));
    ents.push_back(mk(2, 4, 0));
    ents.push_back(mk(2, 6, 1));
    model(ents, exp);
    load_fifo(ents);
    run(exp.size(), 1'b0, ok);
    cnt_exp += exp.size();
    checks++; if (!ok) begin errors++; $display("FAIL rowchg_timeout got=%0d want=%0d", obs.size(), exp.size()); end
    checks++; if (obs.size() !== exp.size()) begin errors++; $display("FAIL rowchg_count got=%0d want=%0d", obs.size(), exp.size()); end
    foreach (exp[i]) begin
      checks++; if (i >= obs.size() || obs[i] !== exp[i]) begin errors++; $display("FAIL rowchg_result[%0d] got=(%0d,%0d) want=(%0d,%0d)", i, obs[i].row, obs[i].val, exp[i].row, exp[i].val); end
    end
    checks++; if (obs.size() < 2 || obs[1] !== {32'd2, 32'd10}) begin errors++; $display("FAIL rowchg_row2 got=(%0d,%0d) want=(2,10)", obs[1].row, obs[1].val); end
    checks++; if (pop_cycles.size() !== 3 || pop_cycles[2] - pop_cycles[0] !== 2) begin errors++; $display("FAIL rowchg_no_stall got span=%0d want=2", pop_cycles[2] - pop_cycles[0]); end
    checks++; if (xfer_cycles.size() < 1 || xfer_cycles[0] - pop_cycles[0] !== 2) begin errors++; $display("FAIL rowchg_latency got=%0d want=2", xfer_cycles[0] - pop_cycles[0]); end
    checks++; if (out_cnt !== cnt_exp) begin errors++; $display("FAIL rowchg_cnt got=%0d want=%0d", out_cnt, cnt_exp); end
  endtask

  task automatic test_last_boundary();
    q_entry_t ents[$];
    res_t     exp[$];
    bit       ok;
    ents.push_back(mk(5, 1, 1));
    ents.push_back(mk(5, 1, 1));
    model(ents, exp);
    load_fifo(ents);
    run(exp.size(), 1'b0, ok);
    cnt_exp += exp.size();
    checks++; if (!ok) begin errors++; $display("FAIL last_timeout got=%0d want=%0d", obs.size(), exp.size()); end
    checks++; if (obs.size() !== 2) begin errors++; $display("FAIL last_no_merge_count got=%0d want=2", obs.size()); end
    foreach (exp[i]) begin
      checks++; if (i >= obs.size() || obs[i] !== exp[i]) begin errors++; $display("FAIL last_result[%0d] got=(%0d,%0d) want=(%0d,%0d)", i, obs[i].row, obs[i].val, exp[i].row, exp[i].val); end
    end
    checks++; if (out_cnt !== cnt_exp) begin errors++; $display("FAIL last_cnt got=%0d want=%0d", out_cnt, cnt_exp); end
  endtask

  task automatic test_hold();
    q_entry_t ents[$];
    res_t     exp[$];
    bit       ok;
    ents.push_back(mk(7, 9, 0));
    ents.push_back(mk(8, 1, 0));
    ents.push_back(mk(9, 2, 1));
    model(ents, exp);
    load_fifo(ents);
    for (int i = 0; i < 6; i++) step(1'b0);
    checks++; if (intf.out_valid !== 1'b1 || intf.out_row !== 32'd7 || intf.out_val !== 32'd9) begin errors++; $display("FAIL hold_outreg got=%b,(%0d,%0d) want=1,(7,9)", intf.out_valid, intf.out_row, intf.out_val); end
    checks++; if (fifo.size() !== 1) begin errors++; $display("FAIL hold_queue_left got=%0d want=1", fifo.size()); end
    checks++; if (intf.q_rd_en !== 1'b0) begin errors++; $display("FAIL hold_rd_en got=%b want=0", intf.q_rd_en); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy got=%b want=1", busy); end
    checks++; if (out_cnt !== cnt_exp) begin errors++; $display("FAIL hold_cnt_frozen got=%0d want=%0d", out_cnt, cnt_exp); end
    run(exp.size(), 1'b0, ok);
    cnt_exp += exp.size();
    checks++; if (!ok) begin errors++; $display("FAIL hold_timeout got=%0d want=%0d", obs.size(), exp.size()); end
    checks++; if (obs.size() !== exp.size()) begin errors++; $display("FAIL hold_count got=%0d want=%0d", obs.size(), exp.size()); end
    foreach (exp[i]) begin
      checks++; if (i >= obs.size() || obs[i] !== exp[i]) begin errors++; $display("FAIL hold_result[%0d] got=(%0d,%0d) want=(%0d,%0d)", i, obs[i].row, obs[i].val, exp[i].row, exp[i].val); end
    end
    checks++; if (out_cnt !== cnt_exp) begin errors++; $display("FAIL hold_final_cnt got=%0d want=%0d", out_cnt, cnt_exp); end
  endtask

  task automatic test_wrap();
    q_entry_t ents[$];
    res_t     exp[$];
    bit       ok;
    ents.push_back(mk(4, 32'hFFFF_FFFF, 0));
    ents.push_back(mk(4, 2, 1));
    model(ents, exp);
    load_fifo(ents);
    run(exp.size(), 1'b0, ok);
    cnt_exp += exp.size();
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got=%0d want=%0d", obs.size(), exp.size()); end
    checks++; if (obs.size() !== 1 || obs[0] !== {32'd4, 32'd1}) begin errors++; $display("FAIL wrap_result got=(%0d,0x%08h) want=(4,0x00000001)", obs[0].row, obs[0].val); end
    checks++; if (out_cnt !== cnt_exp) begin errors++; $display("FAIL wrap_cnt got=%0d want=%0d", out_cnt, cnt_exp); end
  endtask

  task automatic test_back_to_back();
    q_entry_t ents[$];
    res_t     exp[$];
    bit       ok;
    for (int i = 0; i < 8; i++) ents.push_back(mk(20 + i, $urandom(), 1));
    model(ents, exp);
    load_fifo(ents);
    run(exp.size(), 1'b0, ok);
    cnt_exp += exp.size();
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got=%0d want=%0d", obs.size(), exp.size()); end
    checks++; if (obs.size() !== exp.size()) begin errors++; $display("FAIL b2b_count got=%0d want=%0d", obs.size(), exp.size()); end
    foreach (exp[i]) begin
      checks++; if (i >= obs.size() || obs[i] !== exp[i]) begin errors++; $display("FAIL b2b_result[%0d] got=(%0d,%0d) want=(%0d,%0d)", i, obs[i].row, obs[i].val, exp[i].row, exp[i].val); end
    end
    checks++; if (pop_cycles.size() !== 8 || pop_cycles[7] - pop_cycles[0] !== 7) begin errors++; $display("FAIL b2b_pop_rate got span=%0d want=7", pop_cycles[7] - pop_cycles[0]); end
    checks++; if (xfer_cycles.size() !== 8 || xfer_cycles[7] - xfer_cycles[0] !== 7) begin errors++; $display("FAIL b2b_out_rate got span=%0d want=7", xfer_cycles[7] - xfer_cycles[0]); end
    checks++; if (out_cnt !== cnt_exp) begin errors++; $display("FAIL b2b_cnt got=%0d want=%0d", out_cnt, cnt_exp); end
  endtask

  task automatic test_random();
    q_entry_t ents[$];
    res_t     exp[$];
    bit       ok;
    for (int i = 0; i < 200; i++) begin
      ents.push_back(mk($urandom_range(0, 3), $urandom(), (i == 199) || ($urandom_range(0, 3) == 0)));
    end
    model(ents, exp);
    load_fifo(ents);
    run(exp.size(), 1'b1, ok);
    cnt_exp += exp.size();
    checks++; if (!ok) begin errors++; $display("FAIL random_timeout got=%0d want=%0d", obs.size(), exp.size()); end
    checks++; if (obs.size() !== exp.size()) begin errors++; $display("FAIL random_count got=%0d want=%0d", obs.size(), exp.size()); end
    foreach (exp[i]) begin
      checks++; if (i >= obs.size() || obs[i] !== exp[i]) begin errors++; $display("FAIL random_result[%0d] got=(%0d,%0d) want=(%0d,%0d)", i, obs[i].row, obs[i].val, exp[i].row, exp[i].val); end
    end
    checks++; if (out_cnt !== cnt_exp) begin errors++; $display("FAIL random_cnt got=%0d want=%0d", out_cnt, cnt_exp); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL pop_while_empty got=%0d want=0", viol); end
  endtask

  task automatic test_reset_mid_run();
    q_entry_t ents[$];
    res_t     exp[$];
    bit       ok;
    ents.push_back(mk(6, 3, 0));
    load_fifo(ents);
    step(1'b1);
    checks++; if (fifo.size() !== 0) begin errors++; $display("FAIL midrst_popped got=%0d want=0", fifo.size()); end
    rst_b = 1'b0;
    step(1'b1);
    checks++; if (intf.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", intf.out_valid); end
    checks++; if (out_cnt !== 32'd0) begin errors++; $display("FAIL midrst_out_cnt got=%0d want=0", out_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
    rst_b   = 1'b1;
    cnt_exp = 0;
    ents.delete();
    ents.push_back(mk(6, 4, 1));
    model(ents, exp);
    load_fifo(ents);
    run(exp.size(), 1'b0, ok);
    cnt_exp += exp.size();
    checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout got=%0d want=%0d", obs.size(), exp.size()); end
    checks++; if (obs.size() !== 1 || obs[0] !== {32'd6, 32'd4}) begin errors++; $display("FAIL midrst_result got=(%0d,%0d) want=(6,4)", obs[0].row, obs[0].val); end
    checks++; if (out_cnt !== cnt_exp) begin errors++; $display("FAIL midrst_cnt got=%0d want=%0d", out_cnt, cnt_exp); end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    cycle          = 0;
    viol           = 0;
    cnt_exp        = 0;
    rst_b          = 1'b0;
    intf.q_empty   = 1'b1;
    intf.q_data    = '0;
    intf.out_ready = 1'b0;
    test_reset();
    test_single_run();
    test_row_change();
    test_last_boundary();
    test_hold();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=time %0t want=finish earlier", $time);
    $fatal(1, "bench timed out");
  end

endmodule
